// File: rtl/mmio_pkg.sv
// Shared address-map constants and CTRL register layout for the data-side
// memory stage and its timer peripheral.
package mmio_pkg;

    localparam logic [15:0] RAM_BASE_HI = 16'h0000;
    localparam logic [27:0] MMIO_PAGE   = 28'hFFFF000;

    localparam logic [1:0] REG_COUNT = 2'd0;
    localparam logic [1:0] REG_CMP   = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;
    localparam logic [1:0] REG_LED   = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int CTRL_FLAG = 2;
    localparam int CTRL_IE   = 3;

    // Field order mirrors the CTRL bit positions so the struct reads back as-is.
    typedef struct packed {
        logic ie;
        logic flag;
        logic ar;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/mmio_timer.sv
// Free-running timer with compare, auto-reload, sticky match flag and a
// registered interrupt; owns COUNT, CMP and CTRL of the peripheral page.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int TIMER_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        we,
    input  logic [1:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [TIMER_WIDTH-1:0] count;
    logic [TIMER_WIDTH-1:0] cmp;
    ctrl_t                  ctrl;
    logic                   match;
    logic                   ctrlWe;

    // Match only counts while enabled; uses pre-write EN/AR/CMP of this edge.
    assign match  = ctrl.en && (count == cmp);
    assign ctrlWe = we && (sel == REG_CTRL);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
            cmp   <= '0;
            ctrl  <= '0;
            irq   <= 1'b0;
        end else begin
            if (ctrl.en)
                count <= (match && ctrl.ar) ? '0 : count + TIMER_WIDTH'(1);
            if (we && sel == REG_CMP)
                cmp <= wdata[TIMER_WIDTH-1:0];
            if (ctrlWe) begin
                ctrl.en <= wdata[CTRL_EN];
                ctrl.ar <= wdata[CTRL_AR];
                ctrl.ie <= wdata[CTRL_IE];
            end
            // A set from a match beats a write-1-to-clear on the same edge.
            if (match)
                ctrl.flag <= 1'b1;
            else if (ctrlWe && wdata[CTRL_FLAG])
                ctrl.flag <= 1'b0;
            irq <= ctrl.flag & ctrl.ie;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_COUNT: rdata[TIMER_WIDTH-1:0] = count;
            REG_CMP:   rdata[TIMER_WIDTH-1:0] = cmp;
            REG_CTRL:  rdata[3:0]             = ctrl;
            default:   rdata                  = '0;
        endcase
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory stage: word RAM at the bottom 64 KiB, timer and LED registers
// in a four-word page at 0xFFFF0000; zero-latency loads, one-edge stores.
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS   = 64,
    parameter int TIMER_WIDTH = 32
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [15:0] Leds,
    output logic        TimerIrq
);

    localparam int IDX_W = $clog2(RAM_WORDS);

    logic [31:0]      ram [RAM_WORDS];
    logic [IDX_W-1:0] ramIdx;
    logic             isRam;
    logic             isMmio;
    logic [1:0]       regSel;
    logic [15:0]      ledReg;
    logic [31:0]      timerRdata;
    logic             unusedAddr;

    assign isRam      = (Addr[31:16] == RAM_BASE_HI);
    assign isMmio     = (Addr[31:4] == MMIO_PAGE);
    assign regSel     = Addr[3:2];
    // Upper in-region bits are dropped, so RAM aliases across its 64 KiB window.
    assign ramIdx     = Addr[IDX_W+1:2];
    assign unusedAddr = ^Addr[1:0];

    always_ff @(posedge CLK) begin
        if (MemWrite && isRam)
            ram[ramIdx] <= WriteData;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            ledReg <= '0;
        else if (MemWrite && isMmio && regSel == REG_LED)
            ledReg <= WriteData[15:0];
    end

    mmio_timer #(.TIMER_WIDTH(TIMER_WIDTH)) uTimer (
        .clk   (CLK),
        .rstN  (Reset),
        .we    (MemWrite && isMmio),
        .sel   (regSel),
        .wdata (WriteData),
        .rdata (timerRdata),
        .irq   (TimerIrq)
    );

    always_comb begin
        ReadData = '0;
        if (isRam)
            ReadData = ram[ramIdx];
        else if (isMmio)
            ReadData = (regSel == REG_LED) ? {16'h0000, ledReg} : timerRdata;
    end

    assign Leds = ledReg;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: a table of store/load vectors plus hand-written
// timer, interrupt, reset and 4-bit wrap sequences.
module tb_dmem_mmio;

    localparam logic [31:0] A_COUNT = 32'hFFFF0000;
    localparam logic [31:0] A_CMP   = 32'hFFFF0004;
    localparam logic [31:0] A_CTRL  = 32'hFFFF0008;
    localparam logic [31:0] A_LED   = 32'hFFFF000C;

    logic        CLK;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData, ReadData4;
    logic [15:0] Leds, Leds4;
    logic        TimerIrq, TimerIrq4;

    int nChecks = 0;
    int nErrors = 0;

    dmem_mmio #(.RAM_WORDS(64), .TIMER_WIDTH(32)) dut (
        .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .Addr(Addr),
        .WriteData(WriteData), .ReadData(ReadData), .Leds(Leds), .TimerIrq(TimerIrq)
    );

    dmem_mmio #(.RAM_WORDS(64), .TIMER_WIDTH(4)) dut4 (
        .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .Addr(Addr),
        .WriteData(WriteData), .ReadData(ReadData4), .Leds(Leds4), .TimerIrq(TimerIrq4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [31:0] wAddr;
        logic [31:0] wData;
        logic [31:0] rAddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        Addr      = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
        Addr      = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [31:0] d4);
        Addr = a;
        #1;
        d  = ReadData;
        d4 = ReadData4;
    endtask

    task automatic doReset();
        MemWrite = 1'b0;
        Reset    = 1'b0;
        tick();
        Reset    = 1'b1;
    endtask

    logic [31:0] d, d4;

    initial begin
        vecs[0]  = '{1'b1, 32'h00000000, 32'h11111111, 32'h00000000, 32'h11111111, "ram0"};
        vecs[1]  = '{1'b1, 32'h00000008, 32'hDEADBEEF, 32'h00000008, 32'hDEADBEEF, "ramStore"};
        vecs[2]  = '{1'b0, 32'h0,        32'h0,        32'h0000000B, 32'hDEADBEEF, "ramByteOfs"};
        vecs[3]  = '{1'b0, 32'h0,        32'h0,        32'h00000108, 32'hDEADBEEF, "ramAlias"};
        vecs[4]  = '{1'b1, 32'h10000000, 32'h12345678, 32'h10000000, 32'h00000000, "unmappedRd"};
        vecs[5]  = '{1'b0, 32'h0,        32'h0,        32'h00000000, 32'h11111111, "ramAfterUnmapped"};
        vecs[6]  = '{1'b1, 32'h00010008, 32'h0BADF00D, 32'h00000008, 32'hDEADBEEF, "ramAfterHiWrite"};
        vecs[7]  = '{1'b1, 32'hFFFF0010, 32'hFFFFFFFF, 32'hFFFF0010, 32'h00000000, "pageMiss"};
        vecs[8]  = '{1'b1, A_LED,        32'hABCD1234, A_LED,        32'h00001234, "ledRd"};
        vecs[9]  = '{1'b1, A_CMP,        32'hCAFE0001, A_CMP,        32'hCAFE0001, "cmpRd"};
        vecs[10] = '{1'b1, A_COUNT,      32'h00000055, A_COUNT,      32'h00000000, "countReadOnly"};
        vecs[11] = '{1'b1, A_CTRL,       32'hFFFFFFF6, A_CTRL,       32'h00000002, "ctrlMask"};

        Reset = 1'b1; MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;
        #2 Reset = 1'b0;
        #1;
        check("rstLeds", {16'h0, Leds}, 32'h0);
        check("rstIrq", {31'h0, TimerIrq}, 32'h0);
        tick();
        Reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) wr(vecs[i].wAddr, vecs[i].wData);
            rd(vecs[i].rAddr, d, d4);
            check(vecs[i].name, d, vecs[i].exp);
        end
        check("ledsPort", {16'h0, Leds}, 32'h00001234);

        // One-shot: COUNT keeps running past CMP, FLAG sticks from the match.
        doReset();
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h1);
        rd(A_COUNT, d, d4);
        check("osCount0", d, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            rd(A_COUNT, d, d4);
            check($sformatf("osCount%0d", k), d, 32'(k));
            rd(A_CTRL, d, d4);
            check($sformatf("osFlag%0d", k), {31'h0, d[2]}, {31'h0, (k >= 6)});
        end

        // Auto-reload: period of CMP+1.
        doReset();
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h3);
        for (int k = 1; k <= 12; k++) begin
            tick();
            rd(A_COUNT, d, d4);
            check($sformatf("arCount%0d", k), d, 32'(k % 6));
        end

        // Interrupt: IRQ trails FLAG by one edge, clears one edge after FLAG.
        doReset();
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 6; k++) begin
            tick();
            rd(A_CTRL, d, d4);
            check($sformatf("irqFlag%0d", k), {31'h0, d[2]}, {31'h0, (k >= 4)});
            check($sformatf("irqOut%0d", k), {31'h0, TimerIrq}, {31'h0, (k >= 5)});
        end
        wr(A_CTRL, 32'hF);
        rd(A_CTRL, d, d4);
        check("clrFlag", {31'h0, d[2]}, 32'h0);
        check("clrIrqStill", {31'h0, TimerIrq}, 32'h1);
        tick();
        check("clrIrqFall", {31'h0, TimerIrq}, 32'h0);

        // Clear issued on the exact match edge: set wins.
        doReset();
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h9);
        tick(); tick(); tick();
        rd(A_COUNT, d, d4);
        check("simCount", d, 32'd3);
        wr(A_CTRL, 32'hD);
        rd(A_CTRL, d, d4);
        check("simFlagKept", {31'h0, d[2]}, 32'h1);
        wr(A_LED, 32'h0000BEEF);
        check("preRstIrq", {31'h0, TimerIrq}, 32'h1);

        // Asynchronous reset mid-count, between clock edges.
        #2 Reset = 1'b0;
        #1;
        check("midRstLeds", {16'h0, Leds}, 32'h0);
        check("midRstIrq", {31'h0, TimerIrq}, 32'h0);
        for (int r = 0; r < 4; r++) begin
            rd(A_COUNT + 32'(4 * r), d, d4);
            check($sformatf("midRstReg%0d", r), d, 32'h0);
        end
        rd(32'h8, d, d4);
        check("midRstRam", d, 32'hDEADBEEF);
        tick();
        Reset = 1'b1;
        tick(); tick();
        rd(A_COUNT, d, d4);
        check("postRstHeld", d, 32'h0);

        // 4-bit timer wrap: COUNT 15 -> 0, FLAG once per 16 edges.
        doReset();
        wr(A_CMP, 32'd15);
        wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 34; k++) begin
            if (k == 17) wr(A_CTRL, 32'h5);
            else tick();
            rd(A_COUNT, d, d4);
            check($sformatf("wrapCount%0d", k), d4, 32'(k % 16));
            rd(A_CTRL, d, d4);
            check($sformatf("wrapFlag%0d", k), {31'h0, d4[2]}, {31'h0, (k == 16 || k >= 32)});
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
